// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// word-size helper used by the top level and the byte assembler.
package loader_pkg;

   // Loader FSM states (3-bit encoding)
   typedef enum logic [2:0] {
      ST_LEN_HI  = 3'd0,
      ST_LEN_LO  = 3'd1,
      ST_DATA    = 3'd2,
      ST_CHK     = 3'd3,
      ST_RELEASE = 3'd4,
      ST_RUN     = 3'd5,
      ST_ERROR   = 3'd6
   } loader_state_t;

   // Width of the big-endian frame length field
   localparam int unsigned LEN_W = 16;

   // Number of bytes making up one instruction word
   function automatic int unsigned bytes_per_word(input int unsigned instr_w);
      return instr_w / 8;
   endfunction

endpackage

// File: rtl/byte_assembler.sv
// Byte-to-word assembler: shifts bytes in MSB-first and flags the byte that
// completes a word. The completed word is presented combinationally in the
// same cycle as the final byte so the caller can register it once.
module byte_assembler
   import loader_pkg::*;
#(
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [7:0]         in_byte,
   output logic               word_valid,
   output logic [INSTR_W-1:0] word
);

   localparam int unsigned BPW   = bytes_per_word(INSTR_W);
   localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [INSTR_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [INSTR_W-1:0] merged;

   // Merge the incoming byte below the bytes already collected
   always_comb begin
      merged      = shift_q << 8;
      merged[7:0] = in_byte;
      shift_d     = shift_q;
      idx_d       = idx_q;
      word_valid  = 1'b0;
      word        = merged;
      if (in_valid) begin
         shift_d = merged;
         if (idx_q == IDX_W'(BPW - 1)) begin
            word_valid = 1'b1;
            idx_d      = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Shift register and byte index, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte frame over a
// valid/ready handshake, writes assembled words into instruction memory and
// releases the processor PC reset a programmable number of cycles later.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RST_HOLD = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               rx_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               pc_reset,
   output logic               load_done,
   output logic               load_error,
   output logic [ADDR_W:0]    words_loaded
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   loader_state_t      state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [ADDR_W:0]    words_q, words_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [INSTR_W-1:0] wdata_q, wdata_d;
   logic               we_q, we_d;
   logic               ready_q, ready_d;
   logic               pcr_q, pcr_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]         chk_q, chk_d;
`endif

   logic               accept;
   logic               asm_valid;
   logic               word_valid;
   logic [INSTR_W-1:0] asm_word;
   logic [LEN_W:0]     len_ext;
   logic [ADDR_W:0]    words_inc;

   assign accept    = rx_valid & ready_q;
   assign asm_valid = accept && (state_q == ST_DATA);
   assign len_ext   = {1'b0, len_q[LEN_W-1:8], rx_data};
   assign words_inc = words_q + 1'b1;

   byte_assembler #(
      .INSTR_W (INSTR_W)
   ) u_asm (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (asm_valid),
      .in_byte    (rx_data),
      .word_valid (word_valid),
      .word       (asm_word)
   );

   // Next-state and next-output logic of the loader FSM
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      words_d = words_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      pcr_d   = pcr_q;
      done_d  = done_q;
      err_d   = err_q;
      hold_d  = hold_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_d   = chk_q;
`endif
      unique case (state_q)
         ST_LEN_HI: begin
            if (accept) begin
               len_d[LEN_W-1:8] = rx_data;
               state_d          = ST_LEN_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               chk_d            = chk_q ^ rx_data;
`endif
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ rx_data;
`endif
               if (32'(len_ext) > DEPTH) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (len_ext == '0) begin
                  state_d = ST_RELEASE;
                  hold_d  = '0;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (accept) chk_d = chk_q ^ rx_data;
`endif
            if (word_valid) begin
               we_d    = 1'b1;
               addr_d  = words_q[ADDR_W-1:0];
               wdata_d = asm_word;
               words_d = words_inc;
               if (32'(words_inc) == 32'(len_q)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_RELEASE;
`endif
                  hold_d  = '0;
               end
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept) begin
               if (rx_data == chk_q) begin
                  state_d = ST_RELEASE;
                  hold_d  = '0;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         ST_RELEASE: begin
            if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
               state_d = ST_RUN;
               pcr_d   = 1'b0;
               done_d  = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RUN: begin
         end
         ST_ERROR: begin
            pcr_d = 1'b1;
            err_d = 1'b1;
         end
         default: begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
         end
      endcase
      ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                (state_d == ST_DATA)   || (state_d == ST_CHK);
   end

   // State and registered outputs, all cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_LEN_HI;
         len_q   <= '0;
         words_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         pcr_q   <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         words_q <= words_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         pcr_q   <= pcr_d;
         done_q  <= done_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

   assign rx_ready     = ready_q;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign pc_reset     = pcr_q;
   assign load_done    = done_q;
   assign load_error   = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_program_loader;

   localparam int INSTR_W  = 16;
   localparam int ADDR_W   = 8;
   localparam int RST_HOLD = 4;
   localparam int BPW      = INSTR_W / 8;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam longint WMASK = (64'd1 << INSTR_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               rx_valid;
   logic [7:0]         rx_data;
   logic               rx_ready;
   logic               imem_we;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic               pc_reset;
   logic               load_done;
   logic               load_error;
   logic [ADDR_W:0]    words_loaded;

   always #5 clk = ~clk;

   program_loader #(
      .INSTR_W  (INSTR_W),
      .ADDR_W   (ADDR_W),
      .RST_HOLD (RST_HOLD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .pc_reset     (pc_reset),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // frame-level reference model state
   bit         model_valid = 0;
   bit         m_ready, m_we, m_pcr, m_done, m_err;
   int         m_addr, m_words;
   longint     m_wdata, wbuf;
   int         acc, len, hold_left;
   bit         hold_on, chk_wait;
   logic [7:0] chk;

   // logs of observed DUT events
   int cyc = 0;
   int wr_addr[$];
   longint wr_data[$];
   int wr_cyc[$];
   int tk_cyc[$];
   int fall_cyc = -1;
   bit prev_pcr = 1'b1;

   always @(posedge clk) begin : model_p
      logic       take;
      logic [7:0] b;
      cyc++;
      take = rx_valid && m_ready;
      b    = rx_data;
      if (reset) begin
         model_valid = 1;
         m_ready = 0; m_we = 0; m_pcr = 1; m_done = 0; m_err = 0;
         m_addr = 0; m_words = 0; m_wdata = 0; wbuf = 0;
         acc = 0; len = 0; hold_left = 0; hold_on = 0; chk_wait = 0; chk = 0;
      end else begin
         m_we = 0;
         if (hold_on && !m_done) begin
            hold_left--;
            if (hold_left == 0) begin m_pcr = 0; m_done = 1; end
         end
         if (take) begin
            tk_cyc.push_back(cyc);
            acc++;
            if (acc == 1) begin
               len = int'(b) << 8; chk = b;
            end else if (acc == 2) begin
               len = len | int'(b); chk ^= b;
               if (len > DEPTH) m_err = 1;
               else if (len == 0) begin hold_on = 1; hold_left = RST_HOLD; end
            end else if (chk_wait) begin
               chk_wait = 0;
               if (b == chk) begin hold_on = 1; hold_left = RST_HOLD; end
               else m_err = 1;
            end else begin
               chk ^= b;
               wbuf = ((wbuf << 8) | longint'(b)) & WMASK;
               if ((acc - 2) % BPW == 0) begin
                  m_we = 1; m_addr = m_words; m_wdata = wbuf; m_words++;
                  if (m_words == len) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     chk_wait = 1;
`else
                     hold_on = 1; hold_left = RST_HOLD;
`endif
                  end
               end
            end
         end
         m_ready = !(m_err || hold_on);
      end
      #1;
      if (imem_we === 1'b1) begin
         wr_addr.push_back(int'(imem_addr));
         wr_data.push_back(longint'(imem_wdata));
         wr_cyc.push_back(cyc);
      end
      if (prev_pcr && !pc_reset) fall_cyc = cyc;
      prev_pcr = pc_reset;
      if (model_valid) begin
         check("rx_ready",     longint'(rx_ready),     longint'(m_ready));
         check("imem_we",      longint'(imem_we),      longint'(m_we));
         check("imem_addr",    longint'(imem_addr),    longint'(m_addr));
         check("imem_wdata",   longint'(imem_wdata),   m_wdata);
         check("pc_reset",     longint'(pc_reset),     longint'(m_pcr));
         check("load_done",    longint'(load_done),    longint'(m_done));
         check("load_error",   longint'(load_error),   longint'(m_err));
         check("words_loaded", longint'(words_loaded), longint'(m_words));
      end
   end

   task automatic clear_logs();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); tk_cyc.delete();
      fall_cyc = -1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; rx_valid = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      bit ok;
      while ($urandom_range(99) < gap_pct) begin
         rx_valid = 1'b0; rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b1; rx_data = b;
      for (int t = 0; t < 200; t++) begin
         ok = rx_ready;
         @(negedge clk);
         if (ok) begin rx_valid = 1'b0; return; end
      end
      rx_valid = 1'b0;
      check("send_timeout", 0, 1);
   endtask

   task automatic send_frame(input logic [7:0] q[$], input int gap_pct);
      foreach (q[i]) send_byte(q[i], gap_pct);
      rx_valid = 1'b0;
   endtask

   task automatic wait_end(input int max);
      for (int t = 0; t < max; t++) begin
         if (!pc_reset || load_error) begin
            repeat (2) @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      check("wait_end_timeout", 0, 1);
   endtask

   task automatic check_happy(input string tag);
      check({tag, "_wr_count"}, wr_addr.size(), 2);
      if (wr_addr.size() == 2 && tk_cyc.size() >= 6) begin
         check({tag, "_wr0_addr"}, wr_addr[0], 0);
         check({tag, "_wr0_data"}, wr_data[0], 64'h1234);
         check({tag, "_wr1_addr"}, wr_addr[1], 1);
         check({tag, "_wr1_data"}, wr_data[1], 64'hABCD);
         check({tag, "_wr1_latency"}, wr_cyc[1] - tk_cyc[5], 0);
         check({tag, "_release_delay"}, fall_cyc - wr_cyc[1], RST_HOLD);
      end
      check({tag, "_words"}, longint'(words_loaded), 2);
      check({tag, "_done"}, longint'(load_done), 1);
   endtask

   initial begin
      logic [7:0] q[$];
      int bad;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      // reset state literals
      check("rst_rx_ready", longint'(rx_ready), 0);
      check("rst_pc_reset", longint'(pc_reset), 1);
      check("rst_we", longint'(imem_we), 0);
      check("rst_words", longint'(words_loaded), 0);
      check("rst_done_err", longint'({load_done, load_error}), 0);
      reset = 1'b0;
      clear_logs();
      @(negedge clk);
      check("ready_after_reset", longint'(rx_ready), 1);

      // happy path, back-to-back
      q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      send_frame(q, 0);
      wait_end(50);
      check_happy("happy");

      // zero length
      do_reset(2);
      q = {8'h00, 8'h00};
      send_frame(q, 0);
      wait_end(50);
      check("zero_wr_count", wr_addr.size(), 0);
      if (tk_cyc.size() == 2) check("zero_release_delay", fall_cyc - tk_cyc[1], RST_HOLD);
      check("zero_done", longint'(load_done), 1);

      // oversize length, extra traffic while in error
      do_reset(2);
      q = {8'h01, 8'h01};
      send_frame(q, 0);
      check("over_error", longint'(load_error), 1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         rx_valid = 1'(i % 2); rx_data = 8'($urandom);
         @(negedge clk);
         if (pc_reset !== 1'b1 || rx_ready !== 1'b0) bad++;
      end
      rx_valid = 1'b0;
      check("over_hold_bad_cycles", bad, 0);
      check("over_wr_count", wr_addr.size(), 0);

      // gapped handshake plus bytes offered after completion
      do_reset(1);
      q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      send_frame(q, 40);
      wait_end(100);
      check_happy("gap");
      for (int i = 0; i < 20; i++) begin
         rx_valid = 1'b1; rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b0;
      check("gap_extra_wr_count", wr_addr.size(), 2);
      check("gap_extra_words", longint'(words_loaded), 2);

      // reset in the middle of a word
      do_reset(1);
      q = {8'h00, 8'h02, 8'h12};
      send_frame(q, 0);
      do_reset(1);
      q = {8'h00, 8'h01, 8'h56, 8'h78};
      send_frame(q, 0);
      wait_end(50);
      check("midrst_wr_count", wr_addr.size(), 1);
      if (wr_addr.size() == 1) begin
         check("midrst_addr", wr_addr[0], 0);
         check("midrst_data", wr_data[0], 64'h5678);
      end
      check("midrst_words", longint'(words_loaded), 1);

      // full-depth frame
      do_reset(1);
      q = {8'h01, 8'h00};
      for (int i = 0; i < DEPTH * BPW; i++) q.push_back(8'($urandom));
      send_frame(q, 0);
      wait_end(50);
      check("depth_wr_count", wr_addr.size(), DEPTH);
      if (wr_addr.size() == DEPTH) check("depth_last_addr", wr_addr[DEPTH-1], DEPTH - 1);
      check("depth_words", longint'(words_loaded), DEPTH);
      check("depth_done", longint'(load_done), 1);

      // randomized frames with random gaps; model checks every cycle
      for (int it = 0; it < 8; it++) begin
         int n;
         logic [7:0] ck;
         do_reset(1 + $urandom_range(2));
         n = $urandom_range(1, 8);
         q = {8'h00, 8'(n)};
         for (int i = 0; i < n * BPW; i++) q.push_back(8'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ck = 8'h00;
         foreach (q[i]) ck ^= q[i];
         q.push_back(ck);
`else
         ck = 8'h00;
`endif
         send_frame(q, $urandom_range(60));
         wait_end(200);
         check("rand_wr_count", wr_addr.size(), n);
         check("rand_done", longint'(load_done), longint'(ck == ck));
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // checksum: XOR of 00 01 12 34 is 27
      do_reset(1);
      q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      send_frame(q, 0);
      wait_end(50);
      check("chk_good_done", longint'(load_done), 1);
      do_reset(1);
      q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
      send_frame(q, 0);
      wait_end(50);
      check("chk_bad_error", longint'(load_error), 1);
      check("chk_bad_pcr", longint'(pc_reset), 1);
      check("chk_bad_wr_count", wr_addr.size(), 1);
      if (wr_data.size() == 1) check("chk_bad_data", wr_data[0], 64'h1234);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
